irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_edge_det.sv | 29 ++
 rtl/irq_ctrl.sv | 57 +++++
 tb/tb_irq_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: register map, reset values and source indices shared by the interrupt controller.
package irq_pkg;
    localparam int N_SRC = 6;
    localparam logic [31:0] ADDR_PEND = 32'h0000_7F40;
    localparam logic [31:0] ADDR_MASK = 32'h0000_7F44;
    localparam logic [31:0] ADDR_EDGE = 32'h0000_7F48;
    localparam logic [31:0] ADDR_VEC = 32'h0000_7F4C;
    localparam logic [31:0] ADDR_ACK = 32'h0000_7F20;
    localparam logic [N_SRC-1:0] EDGE_RST = 6'b000100;
    localparam int SRC_TIMER0 = 0;
    localparam int SRC_TIMER1 = 1;
    localparam int SRC_EXT = 2;

    // Lowest-numbered active source wins.
    function automatic logic [31:0] vec_of(input logic [N_SRC-1:0] act);
        logic [31:0] v;
        v = 32'h0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (act[i]) v = {1'b1, 26'b0, 5'(i)};
        return v;
    endfunction
endpackage

// File: rtl/irq_edge_det.sv
// irq_edge_det: optional 2-flop synchronizer (IRQ_SYNC_EN) and rising-edge detector.
import irq_pkg::*;

module irq_edge_det (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    output logic [N_SRC-1:0] level,
    output logic [N_SRC-1:0] rise
);
    logic [N_SRC-1:0] src_q;
`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] s1, s2;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= src;
            s2 <= s1;
        end
    end
    assign level = s2;
`else
    assign level = src;
`endif
    always_ff @(posedge clk) src_q <= reset ? '0 : level;
    assign rise = level & ~src_q;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with per-source edge/level mode and mask.
// Define IRQ_SYNC_EN to add a 2-flop input synchronizer.
import irq_pkg::*;

module irq_ctrl (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [31:0]      bus_addr,
    input  logic [31:0]      bus_wdata,
    input  logic [3:0]       bus_byteen,
    output logic [31:0]      bus_rdata,
    output logic [N_SRC-1:0] hw_int
);
    logic [N_SRC-1:0] pend, mask, edge_mode, level, rise, clr, pend_n, active;
    logic [31:0] word;
    logic wr, wr_lane0;
    logic unused_bits;

    irq_edge_det u_det (
        .clk  (clk),
        .reset(reset),
        .src  (src_irq),
        .level(level),
        .rise (rise)
    );

    assign word = {bus_addr[31:2], 2'b00};
    assign wr = |bus_byteen;
    assign wr_lane0 = wr && bus_byteen[0];
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:N_SRC]};
    assign clr = (wr_lane0 && word == ADDR_PEND ? bus_wdata[N_SRC-1:0] : '0)
               | (wr && word == ADDR_ACK ? N_SRC'(1 << SRC_EXT) : '0);
    // Set beats clear in edge mode; level-mode bits simply follow the source.
    assign pend_n = (edge_mode & (rise | (pend & ~clr))) | (~edge_mode & level);
    assign active = pend & mask;
    assign hw_int = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            mask <= '0;
            edge_mode <= EDGE_RST;
        end else begin
            pend <= pend_n;
            if (wr_lane0 && word == ADDR_MASK) mask <= bus_wdata[N_SRC-1:0];
            if (wr_lane0 && word == ADDR_EDGE) edge_mode <= bus_wdata[N_SRC-1:0];
        end
    end

    always_comb begin
        bus_rdata = word == ADDR_PEND ? {26'b0, pend} :
                    word == ADDR_MASK ? {26'b0, mask} :
                    word == ADDR_EDGE ? {26'b0, edge_mode} :
                    word == ADDR_VEC  ? vec_of(active) : 32'h0;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (latency follows IRQ_SYNC_EN).
module tb_irq_ctrl;
`ifdef IRQ_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    logic clk = 0, reset = 1;
    logic [5:0] src_irq = 0;
    logic [31:0] bus_addr = 0, bus_wdata = 0, bus_rdata;
    logic [3:0] bus_byteen = 0;
    logic [5:0] hw_int;
    int checks = 0, errors = 0;

    irq_ctrl dut (
        .clk(clk), .reset(reset), .src_irq(src_irq), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_rdata(bus_rdata), .hw_int(hw_int)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_addr = a;
        bus_wdata = d;
        bus_byteen = be;
        tick();
        bus_byteen = 0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_addr = a;
        bus_byteen = 0;
        #1;
        chk(tag, bus_rdata, exp);
    endtask

    initial begin
        tick(2);
        chk("rst_hw_int", 32'(hw_int), 32'h0);
        rd("rst_pend", 32'h7F40, 32'h0);
        rd("rst_mask", 32'h7F44, 32'h0);
        rd("rst_edge", 32'h7F48, 32'h4);
        rd("rst_vec", 32'h7F4C, 32'h0);
        reset = 0;
        tick();
        // external source rising edge with only bit 2 unmasked
        wr(32'h7F44, 32'h4, 4'b0001);
        src_irq = 6'h04;
        #1;
        chk("pre_edge", 32'(hw_int), 32'h0);
        tick(D + 1);
        chk("edge_set", 32'(hw_int), 32'h4);
        rd("edge_vec", 32'h7F4C, 32'h8000_0002);
        // acknowledge, then acknowledge racing a new rising edge
        wr(32'h7F20, 32'h0, 4'b0001);
        chk("ack_clr", 32'(hw_int), 32'h0);
        src_irq = 0;
        tick(D + 1);
        src_irq = 6'h04;
        tick(D);
        wr(32'h7F20, 32'h0, 4'b0001);
        chk("ack_vs_set", 32'(hw_int), 32'h4);
        // level mode on timers
        src_irq = 0;
        tick(D + 1);
        wr(32'h7F48, 32'h0, 4'b0001);
        wr(32'h7F44, 32'h3, 4'b0001);
        chk("lvl_idle", 32'(hw_int), 32'h0);
        src_irq = 6'h03;
        tick(D + 1);
        chk("lvl_on", 32'(hw_int), 32'h3);
        rd("lvl_vec", 32'h7F4C, 32'h8000_0000);
        tick(2);
        chk("lvl_hold", 32'(hw_int), 32'h3);
        src_irq = 0;
        tick(D);
        chk("lvl_pre_drop", 32'(hw_int), 32'h3);
        tick();
        chk("lvl_drop", 32'(hw_int), 32'h0);
        rd("lvl_vec0", 32'h7F4C, 32'h0);
        // mixed modes and W1C lane handling
        wr(32'h7F48, 32'hFFFF_FF07, 4'b1111);
        wr(32'h7F44, 32'h3F, 4'b0001);
        rd("edge_rd", 32'h7F48, 32'h7);
        wr(32'h7F44, 32'h0, 4'b1110);
        rd("mask_lane", 32'h7F44, 32'h3F);
        src_irq = 6'h1F;
        tick(D + 1);
        chk("mix_set", 32'(hw_int), 32'h1F);
        wr(32'h7F40, 32'h3F, 4'b0010);
        rd("w1c_lane1", 32'h7F40, 32'h1F);
        wr(32'h7F40, 32'h3F, 4'b0001);
        rd("w1c_lane0", 32'h7F40, 32'h18);
        rd("w1c_vec", 32'h7F4C, 32'h8000_0003);
        // reset while pending, with a write that must be ignored
        src_irq = 0;
        tick(D + 1);
        src_irq = 6'h07;
        tick(D + 1);
        rd("pend7", 32'h7F40, 32'h7);
        reset = 1;
        wr(32'h7F48, 32'h3F, 4'b0001);
        chk("rst2_hw_int", 32'(hw_int), 32'h0);
        rd("rst2_pend", 32'h7F40, 32'h0);
        rd("rst2_mask", 32'h7F44, 32'h0);
        rd("rst2_edge", 32'h7F48, 32'h4);
        reset = 0;
        rd("unmapped", 32'h7F50, 32'h0);
        tick();
        chk("post_rst_masked", 32'(hw_int), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
